memory_access_unit: RTL and testbench

Pipeline stage directly downstream of the execute stage. Registers the execute outputs (ALU/system result, store data, control, load/store size) and performs the data-memory transaction through a single-outstanding req/ack interface. Generates byte enables and lane-replicated store data, and extracts and sign- or zero-extends load data. Stalls the pipeline while a transaction is in flight and presents results to write-back plus a forwarding operand to execute.

---
 rtl/memory_access_unit.sv | 219 +++++++++++++++++++++
 tb/tb_memory_access_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_unit.sv
// MEM stage: registers EXE results, runs one req/ack data-memory access, aligns/extends load data.
// Latency 1 cycle for non-memory ops, >=2 for loads/stores; o_stall holds upstream until the ack edge.
package multicore_pkg;
    localparam int DATA_SIZE = 32;
    localparam int INST_SIZE = 32;
    localparam int NUM_REGS  = 32;

    typedef enum logic [2:0] {LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3, LHU = 3'd4} t_ldop;
    typedef enum logic [1:0] {SB = 2'd0, SH = 2'd1, SW = 2'd2} t_sop;
endpackage

module memory_access_unit #(
    parameter int DATA_SIZE = multicore_pkg::DATA_SIZE,
    parameter int INST_SIZE = multicore_pkg::INST_SIZE
) (
    input  logic                                       i_aclk,
    input  logic                                       i_areset_n,
    input  logic                                       i_en,
    input  logic                                       i_flush,
    input  logic [DATA_SIZE-1:0]                       i_exe_calc,
    input  logic [DATA_SIZE-1:0]                       i_exe_wdata,
    input  logic [INST_SIZE-1:0]                       i_pcplus4,
    input  logic [$clog2(multicore_pkg::NUM_REGS)-1:0] i_rdest,
    input  logic                                       i_cu_regwrite,
    input  logic                                       i_cu_memwrite,
    input  logic                                       i_cu_memaccess,
    input  logic [1:0]                                 i_cu_memtoreg,
    input  multicore_pkg::t_ldop                       i_ldop,
    input  multicore_pkg::t_sop                        i_sop,
    output logic                                       o_dmem_req,
    output logic                                       o_dmem_we,
    output logic [INST_SIZE-1:0]                       o_dmem_addr,
    output logic [3:0]                                 o_dmem_be,
    output logic [DATA_SIZE-1:0]                       o_dmem_wdata,
    input  logic                                       i_dmem_ack,
    input  logic [DATA_SIZE-1:0]                       i_dmem_rdata,
    output logic                                       o_stall,
    output logic                                       o_misaligned,
    output logic [DATA_SIZE-1:0]                       o_ma_op,
    output logic [DATA_SIZE-1:0]                       o_exe_calc,
    output logic [DATA_SIZE-1:0]                       o_load_data,
    output logic [INST_SIZE-1:0]                       o_pcplus4,
    output logic [$clog2(multicore_pkg::NUM_REGS)-1:0] o_rdest,
    output logic                                       o_cu_regwrite,
    output logic [1:0]                                 o_cu_memtoreg
);
    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} t_state;

    t_state                                     r_state;
    t_state                                     w_next_state;

    logic [DATA_SIZE-1:0]                       r_calc;
    logic [DATA_SIZE-1:0]                       r_wdata;
    logic [DATA_SIZE-1:0]                       r_rdata;
    logic [INST_SIZE-1:0]                       r_pcplus4;
    logic [$clog2(multicore_pkg::NUM_REGS)-1:0] r_rdest;
    logic [1:0]                                 r_memtoreg;
    multicore_pkg::t_ldop                       r_ldop;
    multicore_pkg::t_sop                        r_sop;
    logic                                       r_regwrite;
    logic                                       r_memwrite;
    logic                                       r_memaccess;
    logic                                       r_misaligned;

    logic [1:0]                                 w_in_size;
    logic                                       w_in_mis;
    logic                                       w_capture;
    logic [1:0]                                 w_size;
    logic [3:0]                                 w_be;
    logic [15:0]                                w_lane;

    // Access size as log2(bytes): 0 byte, 1 half, 2 word.
    always_comb begin
        w_in_size = 2'd2;
        if (i_cu_memwrite) begin
            case (i_sop)
                multicore_pkg::SB: w_in_size = 2'd0;
                multicore_pkg::SH: w_in_size = 2'd1;
                default:           w_in_size = 2'd2;
            endcase
        end else begin
            case (i_ldop)
                multicore_pkg::LB, multicore_pkg::LBU: w_in_size = 2'd0;
                multicore_pkg::LH, multicore_pkg::LHU: w_in_size = 2'd1;
                default:                               w_in_size = 2'd2;
            endcase
        end
    end

    assign w_in_mis  = i_cu_memaccess &
                       (((w_in_size == 2'd1) & i_exe_calc[0]) |
                        ((w_in_size == 2'd2) & (|i_exe_calc[1:0])));
    assign w_capture = (r_state == S_IDLE) & i_en & ~i_flush;

    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_regwrite   <= 1'b0;
            r_memwrite   <= 1'b0;
            r_memaccess  <= 1'b0;
            r_misaligned <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (i_flush) begin
                r_regwrite   <= 1'b0;
                r_memwrite   <= 1'b0;
                r_memaccess  <= 1'b0;
                r_misaligned <= 1'b0;
            end else if (i_en) begin
                r_regwrite   <= i_cu_regwrite & ~w_in_mis;
                r_memwrite   <= i_cu_memwrite;
                r_memaccess  <= i_cu_memaccess;
                r_misaligned <= w_in_mis;
            end
        end else if (i_flush) begin
            // An issued request must complete, so only the write-back is squashed.
            r_regwrite <= 1'b0;
        end
    end

    always_ff @(posedge i_aclk) begin
        if (w_capture) begin
            r_calc     <= i_exe_calc;
            r_wdata    <= i_exe_wdata;
            r_pcplus4  <= i_pcplus4;
            r_rdest    <= i_rdest;
            r_memtoreg <= i_cu_memtoreg;
            r_ldop     <= i_ldop;
            r_sop      <= i_sop;
        end
        if ((r_state == S_BUSY) && i_dmem_ack && !r_memwrite) begin
            r_rdata <= i_dmem_rdata;
        end
    end

    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_capture && i_cu_memaccess && !w_in_mis) w_next_state = S_BUSY;
            S_BUSY: if (i_dmem_ack) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_size = 2'd2;
        if (r_memwrite) begin
            case (r_sop)
                multicore_pkg::SB: w_size = 2'd0;
                multicore_pkg::SH: w_size = 2'd1;
                default:           w_size = 2'd2;
            endcase
        end else begin
            case (r_ldop)
                multicore_pkg::LB, multicore_pkg::LBU: w_size = 2'd0;
                multicore_pkg::LH, multicore_pkg::LHU: w_size = 2'd1;
                default:                               w_size = 2'd2;
            endcase
        end
        case (w_size)
            2'd0:    w_be = 4'b0001 << r_calc[1:0];
            2'd1:    w_be = 4'b0011 << r_calc[1:0];
            default: w_be = 4'b1111;
        endcase
    end

    always_comb begin
        o_dmem_req = 1'b0;
        o_dmem_we  = 1'b0;
        o_dmem_be  = 4'b0000;
        o_stall    = 1'b0;
        case (r_state)
            S_BUSY: begin
                o_dmem_req = r_memaccess;
                o_dmem_we  = r_memwrite;
                o_dmem_be  = w_be;
                o_stall    = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_dmem_addr = {r_calc[INST_SIZE-1:2], 2'b00};

    always_comb begin
        case (r_sop)
            multicore_pkg::SB: o_dmem_wdata = {4{r_wdata[7:0]}};
            multicore_pkg::SH: o_dmem_wdata = {2{r_wdata[15:0]}};
            default:           o_dmem_wdata = r_wdata;
        endcase
    end

    // Bring the addressed byte/half down to lane 0 before extending.
    assign w_lane = 16'(r_rdata >> {r_calc[1:0], 3'b000});

    always_comb begin
        case (r_ldop)
            multicore_pkg::LB:  o_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
            multicore_pkg::LBU: o_load_data = {24'd0, w_lane[7:0]};
            multicore_pkg::LH:  o_load_data = {{16{w_lane[15]}}, w_lane};
            multicore_pkg::LHU: o_load_data = {16'd0, w_lane};
            default:            o_load_data = r_rdata;
        endcase
    end

    assign o_misaligned  = r_misaligned;
    assign o_ma_op       = r_calc;
    assign o_exe_calc    = r_calc;
    assign o_pcplus4     = r_pcplus4;
    assign o_rdest       = r_rdest;
    assign o_cu_regwrite = r_regwrite;
    assign o_cu_memtoreg = r_memtoreg;
endmodule

// File: tb/tb_memory_access_unit.sv
// Bench for memory_access_unit: transaction-level model checked every cycle plus literal expectations.
module tb_memory_access_unit;
    import multicore_pkg::*;

    logic        clk, rst_n, en, flush;
    logic [31:0] calc, wd, pc, rdata;
    logic [4:0]  rdest;
    logic        rw, mw, ma, ack;
    logic [1:0]  m2r;
    t_ldop       ldop;
    t_sop        sop;

    logic        req, we, stall, mis, o_rw;
    logic [31:0] addr, wdat, ma_op, o_calc, ld_data, o_pc;
    logic [3:0]  be;
    logic [4:0]  o_rdest;
    logic [1:0]  o_m2r;

    int total = 0;
    int bad   = 0;

    memory_access_unit dut (
        .i_aclk(clk), .i_areset_n(rst_n), .i_en(en), .i_flush(flush),
        .i_exe_calc(calc), .i_exe_wdata(wd), .i_pcplus4(pc), .i_rdest(rdest),
        .i_cu_regwrite(rw), .i_cu_memwrite(mw), .i_cu_memaccess(ma), .i_cu_memtoreg(m2r),
        .i_ldop(ldop), .i_sop(sop),
        .o_dmem_req(req), .o_dmem_we(we), .o_dmem_addr(addr), .o_dmem_be(be),
        .o_dmem_wdata(wdat), .i_dmem_ack(ack), .i_dmem_rdata(rdata),
        .o_stall(stall), .o_misaligned(mis), .o_ma_op(ma_op), .o_exe_calc(o_calc),
        .o_load_data(ld_data), .o_pcplus4(o_pc), .o_rdest(o_rdest),
        .o_cu_regwrite(o_rw), .o_cu_memtoreg(o_m2r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic is_st, input t_ldop l, input t_sop s);
        if (is_st) return (s == SB) ? 1 : (s == SH) ? 2 : 4;
        return (l == LB || l == LBU) ? 1 : (l == LH || l == LHU) ? 2 : 4;
    endfunction

    function automatic logic [31:0] load_model(input logic [31:0] word, input logic [1:0] off, input t_ldop l);
        int n;
        logic [31:0] v, mask;
        n = nbytes(1'b0, l, SB);
        if (n == 4) return word;
        mask = (n == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        v = (word >> (8 * off)) & mask;
        if ((l == LB || l == LH) && ((v & ((mask + 1) >> 1)) != 0)) v = v | ~mask;
        return v;
    endfunction

    // Model: instruction currently held by the stage and whether its access is outstanding.
    logic        m_busy, m_rw, m_mw, m_ma, m_mis, m_data_ok, m_rd_ok;
    logic [31:0] m_calc, m_wd, m_pc, m_rdata;
    logic [4:0]  m_rdest;
    logic [1:0]  m_m2r;
    t_ldop       m_ldop;
    t_sop        m_sop;

    initial begin
        m_busy = 0; m_rw = 0; m_mw = 0; m_ma = 0; m_mis = 0; m_data_ok = 0; m_rd_ok = 0;
        m_calc = 0; m_wd = 0; m_pc = 0; m_rdata = 0; m_rdest = 0; m_m2r = 0;
        m_ldop = LW; m_sop = SW;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy = 0; m_rw = 0; m_mw = 0; m_ma = 0; m_mis = 0;
            end else if (m_busy) begin
                if (flush) m_rw = 0;
                if (ack) begin
                    if (!m_mw) begin m_rdata = rdata; m_rd_ok = 1; end
                    m_busy = 0;
                end
            end else if (flush) begin
                m_rw = 0; m_mw = 0; m_ma = 0; m_mis = 0;
            end else if (en) begin
                m_calc = calc; m_wd = wd; m_pc = pc; m_rdest = rdest; m_m2r = m2r;
                m_ldop = ldop; m_sop = sop; m_mw = mw; m_ma = ma; m_data_ok = 1;
                m_mis  = ma && ((calc % nbytes(mw, ldop, sop)) != 0);
                m_rw   = rw && !m_mis;
                m_busy = ma && !m_mis;
            end
        end
    end

    initial begin
        int n;
        logic [7:0]  be8;
        logic [31:0] wexp;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                n = nbytes(m_mw, m_ldop, m_sop);
                be8 = m_busy ? (8'((1 << n) - 1) << m_calc[1:0]) : 8'h00;
                chk("req", {31'd0, req}, {31'd0, m_busy});
                chk("stall", {31'd0, stall}, {31'd0, m_busy});
                chk("we", {31'd0, we}, {31'd0, m_busy & m_mw});
                chk("be", {28'd0, be}, {28'd0, be8[3:0]});
                chk("misaligned", {31'd0, mis}, {31'd0, m_mis});
                chk("regwrite", {31'd0, o_rw}, {31'd0, m_rw});
                if (m_data_ok) begin
                    chk("ma_op", ma_op, m_calc);
                    chk("exe_calc", o_calc, m_calc);
                    chk("pcplus4", o_pc, m_pc);
                    chk("rdest", {27'd0, o_rdest}, {27'd0, m_rdest});
                    chk("memtoreg", {30'd0, o_m2r}, {30'd0, m_m2r});
                    if (m_busy) chk("addr", addr, m_calc & 32'hFFFF_FFFC);
                    if (m_busy && m_mw) begin
                        wexp = (n == 1) ? m_wd[7:0] * 32'h0101_0101 :
                               (n == 2) ? m_wd[15:0] * 32'h0001_0001 : m_wd;
                        chk("wdata", wdat, wexp);
                    end
                    if (m_rd_ok) chk("load_data", ld_data, load_model(m_rdata, m_calc[1:0], m_ldop));
                end
            end
        end
    end

    // Leaves the caller at the falling edge after the capture edge (cycle N+1).
    task automatic issue(input logic [31:0] c, input logic [31:0] w, input logic r, input logic m_w,
                         input logic m_a, input t_ldop l, input t_sop s);
        @(negedge clk);
        calc = c; wd = w; pc = c + 32'd4; rdest = c[4:0] + 5'd1; m2r = c[5:4];
        rw = r; mw = m_w; ma = m_a; ldop = l; sop = s; en = 1;
        @(negedge clk);
        en = 0;
    endtask

    task automatic ack_after(input int k, input logic [31:0] rd);
        repeat (k - 1) @(negedge clk);
        ack = 1; rdata = rd;
        @(negedge clk);
        ack = 0;
    endtask

    initial begin
        rst_n = 0; en = 0; flush = 0; calc = 0; wd = 0; pc = 0; rdest = 0;
        rw = 0; mw = 0; ma = 0; m2r = 0; ldop = LW; sop = SW; ack = 0; rdata = 0;
        repeat (3) @(negedge clk);
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_regwrite", {31'd0, o_rw}, 32'd0);
        chk("rst_mis", {31'd0, mis}, 32'd0);
        chk("rst_be", {28'd0, be}, 32'd0);
        rst_n = 1;

        issue(32'h55, 32'h0, 1, 0, 0, LW, SW);
        chk("add_ma_op", ma_op, 32'h55);
        chk("add_exe_calc", o_calc, 32'h55);
        chk("add_req", {31'd0, req}, 32'd0);
        chk("add_stall", {31'd0, stall}, 32'd0);

        issue(32'h1004, 32'hDEADBEEF, 0, 1, 1, LW, SW);
        chk("sw_addr", addr, 32'h1004);
        chk("sw_be", {28'd0, be}, 32'hF);
        chk("sw_we", {31'd0, we}, 32'd1);
        chk("sw_stall_n1", {31'd0, stall}, 32'd1);
        ack_after(3, 32'h0);
        chk("sw_stall_n4", {31'd0, stall}, 32'd0);
        chk("sw_req_n4", {31'd0, req}, 32'd0);

        issue(32'h2003, 32'h0, 1, 0, 1, LB, SB);
        ack_after(1, 32'h80FF_7F01);
        chk("lb_data", ld_data, 32'hFFFF_FF80);
        chk("lb_regwrite", {31'd0, o_rw}, 32'd1);
        issue(32'h2003, 32'h0, 1, 0, 1, LBU, SB);
        ack_after(1, 32'h80FF_7F01);
        chk("lbu_data", ld_data, 32'h0000_0080);
        issue(32'h2002, 32'h0, 1, 0, 1, LH, SB);
        ack_after(2, 32'h80FF_7F01);
        chk("lh_data", ld_data, 32'hFFFF_80FF);
        issue(32'h2000, 32'h0, 1, 0, 1, LHU, SB);
        ack_after(1, 32'h80FF_7F01);
        chk("lhu_data", ld_data, 32'h0000_7F01);
        issue(32'h2000, 32'h0, 1, 0, 1, LW, SB);
        ack_after(1, 32'h80FF_7F01);
        chk("lw_data", ld_data, 32'h80FF_7F01);

        issue(32'h3002, 32'h1234ABCD, 0, 1, 1, LW, SH);
        chk("sh_be", {28'd0, be}, 32'hC);
        chk("sh_wdata", wdat, 32'hABCD_ABCD);
        ack_after(2, 32'h0);
        issue(32'h7001, 32'h0000_00AB, 0, 1, 1, LW, SB);
        chk("sb_be", {28'd0, be}, 32'h2);
        chk("sb_wdata", wdat, 32'hABAB_ABAB);
        ack_after(1, 32'h0);

        issue(32'h4002, 32'h0, 1, 0, 1, LW, SW);
        chk("mis_flag", {31'd0, mis}, 32'd1);
        chk("mis_req", {31'd0, req}, 32'd0);
        chk("mis_regwrite", {31'd0, o_rw}, 32'd0);
        chk("mis_stall", {31'd0, stall}, 32'd0);
        issue(32'h3001, 32'h0, 0, 1, 1, LW, SH);
        chk("mis_sh_flag", {31'd0, mis}, 32'd1);

        // Ack with no access outstanding must be ignored.
        issue(32'h4002, 32'h0, 1, 0, 1, LW, SW);
        ack = 1; rdata = 32'h1234_5678;
        @(negedge clk);
        ack = 0;
        chk("idle_ack_stall", {31'd0, stall}, 32'd0);
        chk("idle_ack_data", ld_data, 32'h80FF_7F01);

        @(negedge clk);
        calc = 32'h8000; rw = 1; mw = 0; ma = 1; ldop = LW; en = 1; flush = 1;
        @(negedge clk);
        en = 0; flush = 0;
        chk("flush_en_req", {31'd0, req}, 32'd0);
        chk("flush_en_regwrite", {31'd0, o_rw}, 32'd0);

        issue(32'h5000, 32'h0, 1, 0, 1, LW, SW);
        flush = 1;
        @(negedge clk);
        flush = 0;
        chk("flush_busy_req", {31'd0, req}, 32'd1);
        chk("flush_busy_regwrite", {31'd0, o_rw}, 32'd0);
        ack_after(1, 32'hCAFE_F00D);
        chk("flush_done_stall", {31'd0, stall}, 32'd0);
        chk("flush_done_regwrite", {31'd0, o_rw}, 32'd0);

        issue(32'h6000, 32'h0, 1, 0, 1, LW, SW);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_req", {31'd0, req}, 32'd0);
        chk("arst_stall", {31'd0, stall}, 32'd0);
        chk("arst_regwrite", {31'd0, o_rw}, 32'd0);
        @(negedge clk);
        rst_n = 1;

        issue(32'h99, 32'h0, 1, 0, 0, LW, SW);
        chk("post_rst_regwrite", {31'd0, o_rw}, 32'd1);
        chk("post_rst_ma_op", ma_op, 32'h99);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
